reg_wb_ctrl: RTL and testbench

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

---
 rtl/reg_wb_ctrl_pkg.sv | 15 +
 rtl/wb_fifo.sv | 55 +++++
 rtl/reg_wb_ctrl.sv | 101 ++++++++++
 tb/tb_reg_wb_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_ctrl_pkg.sv
// Shared register-file constants and the write-back queue entry format.
package reg_wb_ctrl_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [REG_AW-1:0] X0 = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-response FIFO holding {rd,data} entries; DEPTH must be a power of two.
module wb_fifo
  import reg_wb_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  wb_entry_t       i_entry,
  input  logic            i_pop,
  output wb_entry_t       o_head,
  output logic [CW-1:0]   o_count,
  output logic            o_full,
  output logic            o_empty
);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_entry;
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back arbiter: ALU results beat queued load responses;
// a pending-load scoreboard drives the decode stall.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_issue_rd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  output logic              stall,
  output logic [REG_AW-1:0] w_reg,
  output logic [XLEN-1:0]   w_data,
  output logic              RegWEn
);

  localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

  wb_entry_t           w_head;
  wb_entry_t           w_entry;
  logic [CW-1:0]       w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_pending_nxt;

  logic [NUM_REGS-1:0] r_pending;
  logic                r_wen;
  logic [REG_AW-1:0]   r_wreg;
  logic [XLEN-1:0]     r_wdata;

  assign ld_ready = (w_count < CW'(LQ_DEPTH));
  assign w_push   = ld_valid && !w_full;
  assign w_pop    = !alu_valid && !w_empty;
  assign w_entry  = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Issue sets, a committed load clears; set is applied last so it wins.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (ld_issue && (ld_issue_rd != X0)) w_set[ld_issue_rd] = 1'b1;
    if (w_pop && (w_head.rd != X0))      w_clr[w_head.rd]    = 1'b1;
    w_pending_nxt    = (r_pending & ~w_clr) | w_set;
    w_pending_nxt[0] = 1'b0;
  end

  assign stall = r_pending[dec_rs1] | r_pending[dec_rs2] | r_pending[dec_rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_wen     <= 1'b0;
      r_wreg    <= '0;
      r_wdata   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (alu_valid) begin
        r_wen   <= (alu_rd != X0);
        r_wreg  <= alu_rd;
        r_wdata <= alu_data;
      end else if (w_pop) begin
        r_wen   <= (w_head.rd != X0);
        r_wreg  <= w_head.rd;
        r_wdata <= w_head.data;
      end else begin
        r_wen   <= 1'b0;
      end
    end
  end

  assign RegWEn = r_wen;
  assign w_reg  = r_wreg;
  assign w_data = r_wdata;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed and random checks of reg_wb_ctrl against a queue/bitmap reference model.
module tb_reg_wb_ctrl;

  localparam int LQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        stall;
  logic [4:0]  w_reg;
  logic [31:0] w_data;
  logic        RegWEn;

  always #5 clk = ~clk;

  reg_wb_ctrl #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .stall(stall), .w_reg(w_reg), .w_data(w_data), .RegWEn(RegWEn)
  );

  typedef struct {
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  int        n_chk  = 0;
  int        n_fail = 0;
  ent_t      mq[$];
  bit [31:0] m_pend;
  bit        m_wen;
  bit [4:0]  m_reg;
  bit [31:0] m_data;
  bit        m_acc;
  int        got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already applied at a negedge; returns at the next negedge.
  task automatic step();
    ent_t e;
    #1;
    chk("ld_ready", ld_ready, 32'(mq.size() < LQ_DEPTH));
    chk("stall", stall, 32'(m_pend[dec_rs1] | m_pend[dec_rs2] | m_pend[dec_rd]));
    m_acc = ld_valid && (mq.size() < LQ_DEPTH);
    if (alu_valid) begin
      m_wen = (alu_rd != 0); m_reg = alu_rd; m_data = alu_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_wen = (e.rd != 0); m_reg = e.rd; m_data = e.data;
      m_pend[e.rd] = 1'b0;
    end else begin
      m_wen = 1'b0;
    end
    if (m_acc) mq.push_back('{ld_rd, ld_data});
    if (ld_issue) m_pend[ld_issue_rd] = 1'b1;
    m_pend[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("RegWEn", RegWEn, 32'(m_wen));
    if (m_wen) begin
      chk("w_reg", w_reg, 32'(m_reg));
      chk("w_data", w_data, m_data);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  initial begin
    idle_inputs();
    m_pend = '0; m_wen = 0; m_reg = 0; m_data = 0; m_acc = 1;
    rst = 1'b0;
    #12;
    chk("rst_wen", RegWEn, 0);
    chk("rst_wreg", w_reg, 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_ready", ld_ready, 1);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b1;

    // ALU write appears on the first edge after reset release
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    chk("alu_wen", RegWEn, 1);
    chk("alu_wreg", w_reg, 5);
    chk("alu_wdata", w_data, 32'hDEADBEEF);
    idle_inputs();

    // Load to x7: stall while pending, drops the cycle the write lands
    ld_issue = 1; ld_issue_rd = 7;
    step();
    ld_issue = 0; dec_rs1 = 7;
    #1 chk("raw_stall", stall, 1);
    ld_valid = 1; ld_rd = 7; ld_data = 32'h12;
    step();
    ld_valid = 0;
    step();
    chk("ld7_wen", RegWEn, 1);
    chk("ld7_wreg", w_reg, 7);
    chk("ld7_wdata", w_data, 32'h12);
    chk("ld7_stall", stall, 0);
    idle_inputs();

    // Queue fills behind four ALU cycles; loads drain in arrival order
    alu_valid = 1; alu_rd = 20; alu_data = 32'h100;
    ld_valid = 1; ld_rd = 10; ld_data = 32'hA0;
    step();
    ld_rd = 11; ld_data = 32'hB0; alu_data = 32'h101;
    step();
    ld_rd = 12; ld_data = 32'hC0; alu_data = 32'h102;
    chk("lq_full_ready", ld_ready, 0);
    step();
    alu_data = 32'h103;
    step();
    alu_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (m_acc) ld_valid = 0;
      if (RegWEn) got.push_back(int'(w_reg));
    end
    chk("order_n", got.size(), 3);
    while (got.size() < 3) got.push_back(-1);
    chk("order_0", got[0], 10);
    chk("order_1", got[1], 11);
    chk("order_2", got[2], 12);
    idle_inputs();

    // Writes to x0 are suppressed and leave pending bits alone
    ld_issue = 1; ld_issue_rd = 3;
    step();
    ld_issue = 0; alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    step();
    chk("x0_alu_wen", RegWEn, 0);
    alu_valid = 0; ld_valid = 1; ld_rd = 0; ld_data = 32'h66;
    step();
    ld_valid = 0; dec_rs1 = 3;
    step();
    chk("x0_ld_wen", RegWEn, 0);
    chk("x0_pend3", stall, 1);
    ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
    step();
    ld_valid = 0;
    step();
    chk("x3_clear", stall, 0);
    idle_inputs();

    // Same-edge clear and set of x9: set wins
    ld_issue = 1; ld_issue_rd = 9;
    step();
    ld_issue = 0; ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    step();
    ld_valid = 0; ld_issue = 1; ld_issue_rd = 9;
    step();
    ld_issue = 0; dec_rs2 = 9;
    chk("x9_wen", RegWEn, 1);
    #1 chk("x9_stall", stall, 1);
    idle_inputs();
    ld_valid = 1; ld_rd = 9; ld_data = 32'h9A;
    step();
    ld_valid = 0;
    step();

    // Reset with two queued loads discards them
    ld_issue = 1; ld_issue_rd = 4;
    step();
    ld_issue = 0; alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
    ld_valid = 1; ld_rd = 3; ld_data = 32'h300;
    step();
    ld_rd = 4; ld_data = 32'h400;
    step();
    ld_valid = 0; alu_valid = 0; dec_rs1 = 4;
    chk("pre_rst_count", 32'(mq.size()), 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_wen", RegWEn, 0);
    chk("arst_wreg", w_reg, 0);
    chk("arst_wdata", w_data, 0);
    chk("arst_ready", ld_ready, 1);
    chk("arst_stall", stall, 0);
    mq.delete(); m_pend = '0;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Random traffic; a refused load response is held until accepted
    m_acc = 1;
    for (int i = 0; i < 400; i++) begin
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd = 5'($urandom_range(0, 15));
      alu_data = $urandom;
      ld_issue = ($urandom_range(0, 2) == 0);
      ld_issue_rd = 5'($urandom_range(0, 7));
      if (!(ld_valid && !m_acc)) begin
        ld_valid = ($urandom_range(0, 1) == 1);
        ld_rd = 5'($urandom_range(0, 7));
        ld_data = $urandom;
      end
      dec_rs1 = 5'($urandom_range(0, 7));
      dec_rs2 = 5'($urandom_range(0, 7));
      dec_rd = 5'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
